fetch_unit: RTL

Instruction-fetch stage that produces the instruction word and next-PC value written into the fetch/decode pipeline latch each cycle. Owns the program counter, drives the synchronous instruction memory (one-cycle read latency), and generates the latch write enable. It absorbs hazard stalls with a one-entry hold buffer and injects bubbles on control-flow redirects.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit_hold_buf.sv | 33 +++
 rtl/fetch_unit.sv | 92 +++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: bubble encoding and fetch FSM state encoding.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and FD-latch outputs.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic [31:0]       out_IR;
  logic [31:0]       out_PC_next;
  logic              fd_wren;
  logic              fetch_valid;

  modport master (
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  imem_q,
    output imem_addr,
    output out_IR,
    output out_PC_next,
    output fd_wren,
    output fetch_valid
  );

  modport slave (
    output stall,
    output redirect,
    output redirect_pc,
    output imem_q,
    input  imem_addr,
    input  out_IR,
    input  out_PC_next,
    input  fd_wren,
    input  fetch_valid
  );

endinterface

// File: rtl/fetch_unit_hold_buf.sv
// One-entry hold buffer: captures the returning ROM word when a stall hits a live fetch.
module fetch_unit_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  fetch_state_e state_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  imem_q_i,
  output logic [31:0]  hold_ir_o
);

  logic        capture;
  logic [31:0] hold_ir_d, hold_ir_q;

  // Only the first stalled cycle out of RUN captures; HOLD keeps the word until state moves on.
  always_comb begin
    capture   = stall_i && !redirect_i && (state_i == StRun);
    hold_ir_d = capture ? imem_q_i : hold_ir_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_ir_q <= NOP;
    end else begin
      hold_ir_q <= hold_ir_d;
    end
  end

  assign hold_ir_o = hold_ir_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns pc, drives the synchronous ROM and feeds the FD latch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  req_pc_d, req_pc_q;
  logic [31:0]  hold_ir;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StFill;
      pc_q     <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      state_d = StFill;
    end else if (!bus.stall) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:   state_d = StHold;
        StHold:  state_d = StHold;
        StFill:  state_d = StFill;
        default: state_d = StFill;
      endcase
    end
  end

  // req_pc tracks the word now in flight in the ROM; a redirect leaves it alone.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (!bus.stall) begin
      pc_d     = pc_q + 32'd1;
      req_pc_d = pc_q;
    end
  end

  always_comb begin
    bus.out_IR      = NOP;
    bus.fetch_valid = 1'b0;
    if (!bus.redirect) begin
      unique case (state_q)
        StRun: begin
          bus.out_IR      = bus.imem_q;
          bus.fetch_valid = 1'b1;
        end
        StHold: begin
          bus.out_IR      = hold_ir;
          bus.fetch_valid = 1'b1;
        end
        default: begin
          bus.out_IR      = NOP;
          bus.fetch_valid = 1'b0;
        end
      endcase
    end
  end

  assign bus.out_PC_next = req_pc_q + 32'd1;
  assign bus.fd_wren     = ~bus.stall | bus.redirect;
  assign bus.imem_addr   = pc_q[ADDR_W-1:0];

  fetch_unit_hold_buf u_hold_buf (
    .clk_i      (clock),
    .rst_ni     (reset),
    .state_i    (state_q),
    .stall_i    (bus.stall),
    .redirect_i (bus.redirect),
    .imem_q_i   (bus.imem_q),
    .hold_ir_o  (hold_ir)
  );

endmodule
